// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I control FSM driving datapath selects, enables and ALU control
module multicycle_ctrl #(
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              adr_src,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic [1:0]        result_src,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        imm_src,
    output logic [ALUC_W-1:0] alu_control,
    output logic              illegal_instr
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(5);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL
    } state_t;

    state_t state, next;
    logic pcw, mw, irw, rw, ill;
    logic [ALUC_W-1:0] alu_fn;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= FETCH;
        else        state <= next;

    // op[5] separates R-type sub from I-type addi, which has no sub form
    always_comb
        alu_fn = funct3 == 3'b000 ? ((op[5] && funct7b5) ? ALU_SUB : ALU_ADD) :
                 funct3 == 3'b010 ? ALU_SLT :
                 funct3 == 3'b110 ? ALU_OR  :
                 funct3 == 3'b111 ? ALU_AND : ALU_ADD;

    assign imm_src = op == OP_SW  ? 2'b01 :
                     op == OP_B   ? 2'b10 :
                     op == OP_JAL ? 2'b11 : 2'b00;

    always_comb begin
        next        = state;
        pcw         = 1'b0;
        mw          = 1'b0;
        irw         = 1'b0;
        rw          = 1'b0;
        ill         = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                irw        = mem_ready;
                pcw        = mem_ready;
                next       = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXECR;
                    OP_I:         next = EXECI;
                    OP_B:         next = BRANCH;
                    OP_JAL:       next = JAL;
                    default: begin
                        next = FETCH;
                        ill  = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                next      = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                next    = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                rw         = 1'b1;
                next       = FETCH;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mw      = 1'b1;
                next    = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_fn;
                next        = ALUWB;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_fn;
                next        = ALUWB;
            end
            ALUWB: begin
                rw   = 1'b1;
                next = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pcw         = zero ^ funct3[0];
                next        = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pcw       = 1'b1;
                next      = ALUWB;
            end
            default: next = FETCH;
        endcase
    end

    // enables are gated so nothing can be written while reset is held
    assign pc_write      = reset & pcw;
    assign mem_write     = reset & mw;
    assign ir_write      = reset & irw;
    assign reg_write     = reset & rw;
    assign illegal_instr = reset & ill;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized check of multicycle_ctrl against a per-instruction cycle-sequence model
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic funct7b5 = 1'b0;
    logic zero = 1'b0;
    logic mem_ready = 1'b1;
    logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [16:0] obs;
    logic [16:0] exp_q[$], msk_q[$], obs_q[$];
    logic mr_q[$];
    logic [1:0] cur_imm;
    int total = 0;
    int bad = 0;

    localparam logic [4:0] DA = 5'b10000, DR = 5'b01000, DSA = 5'b00100, DSB = 5'b00010, DL = 5'b00001;

    multicycle_ctrl #(.ALUC_W(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr,
                  result_src, alu_src_a, alu_src_b, alu_control, imm_src};

    function automatic logic legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [2:0] ref_fn(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic add(input logic pcw, input logic adr, input logic mw, input logic irw,
                       input logic rw, input logic ill, input logic [1:0] rs, input logic [1:0] a,
                       input logic [1:0] b, input logic [2:0] alu, input logic [4:0] dc, input logic mr);
        exp_q.push_back({pcw, adr, mw, irw, rw, ill, rs, a, b, alu, cur_imm});
        msk_q.push_back(~{1'b0, dc[4], 4'b0, {2{dc[3]}}, {2{dc[2]}}, {2{dc[1]}}, {3{dc[0]}}, 2'b0});
        mr_q.push_back(mr);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // expected per-cycle outputs for one instruction, with fw/mwt stall cycles in fetch/memory
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                         input int fw, input int mwt);
        logic [2:0] fn;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        exp_q.delete(); msk_q.delete(); mr_q.delete(); obs_q.delete();
        cur_imm = o == 7'b0100011 ? 2'b01 : o == 7'b1100011 ? 2'b10 : o == 7'b1101111 ? 2'b11 : 2'b00;
        fn = ref_fn(o, f3, f7);
        repeat (fw) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 5'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 5'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !legal(o), 2'b00, 2'b01, 2'b01, 3'b000, DA | DR, rb());
        if (o == 7'b0000011 || o == 7'b0100011) begin
            add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, DA | DR, rb());
            for (int i = 0; i <= mwt; i++)
                add(1'b0, 1'b1, o[5], 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, DSA | DSB | DL, i == mwt);
            if (!o[5]) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, DA | DSA | DSB | DL, rb());
        end else if (o == 7'b0110011 || o == 7'b0010011 || o == 7'b1101111) begin
            if (o == 7'b1101111) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, DA, rb());
            else add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, {1'b0, !o[5]}, fn, DA | DR, rb());
            add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, DA | DSA | DSB | DL, rb());
        end else if (o == 7'b1100011) begin
            add(z ^ f3[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, DA, rb());
        end
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = mr_q[i];
            #1 obs_q.push_back(obs);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        repeat (3) begin
            #1 total++;
            if ({pc_write, mem_write, ir_write, reg_write, illegal_instr} !== 5'b0) begin
                bad++; $display("FAIL reset_en got=%b want=00000", {pc_write, mem_write, ir_write, reg_write, illegal_instr});
            end
            total++;
            if ({adr_src, result_src, alu_src_a, alu_src_b, alu_control} !== 10'b0_10_00_10_000) begin
                bad++; $display("FAIL reset_sel got=%b want=0100010000", {adr_src, result_src, alu_src_a, alu_src_b, alu_control});
            end
            @(negedge clk);
        end
        reset = 1'b1;
    endtask

    task automatic test_rtype();
        build(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
        drive(exp_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (((obs_q[i] ^ exp_q[i]) & msk_q[i]) != 17'd0) begin
                bad++; $display("FAIL rtype cyc=%0d got=%h want=%h mask=%h", i, obs_q[i], exp_q[i], msk_q[i]);
            end
        end
    endtask

    task automatic test_lw_stall();
        build(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2);
        drive(exp_q.size());
        total++;
        if (obs_q.size() != 7) begin
            bad++; $display("FAIL lw_len got=%0d want=7", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (((obs_q[i] ^ exp_q[i]) & msk_q[i]) != 17'd0) begin
                bad++; $display("FAIL lw_stall cyc=%0d got=%h want=%h mask=%h", i, obs_q[i], exp_q[i], msk_q[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0] cases [3];
        cases[0] = {3'b000, 1'b1}; cases[1] = {3'b001, 1'b1}; cases[2] = {3'b001, 1'b0};
        for (int k = 0; k < 3; k++) begin
            build(7'b1100011, cases[k][3:1], 1'b0, cases[k][0], 0, 0);
            drive(exp_q.size());
            for (int i = 0; i < obs_q.size(); i++) begin
                total++;
                if (((obs_q[i] ^ exp_q[i]) & msk_q[i]) != 17'd0) begin
                    bad++; $display("FAIL branch%0d cyc=%0d got=%h want=%h mask=%h", k, i, obs_q[i], exp_q[i], msk_q[i]);
                end
            end
        end
    endtask

    task automatic test_alu_decode();
        logic [3:0] cases [4];
        cases[0] = {3'b110, 1'b0}; cases[1] = {3'b111, 1'b0}; cases[2] = {3'b010, 1'b0}; cases[3] = {3'b000, 1'b1};
        for (int k = 0; k < 4; k++) begin
            build(7'b0010011, cases[k][3:1], cases[k][0], 1'b0, 0, 0);
            drive(exp_q.size());
            for (int i = 0; i < obs_q.size(); i++) begin
                total++;
                if (((obs_q[i] ^ exp_q[i]) & msk_q[i]) != 17'd0) begin
                    bad++; $display("FAIL alu_dec%0d cyc=%0d got=%h want=%h mask=%h", k, i, obs_q[i], exp_q[i], msk_q[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        build(7'b1111111, 3'b000, 1'b0, 1'b0, 1, 0);
        drive(exp_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (((obs_q[i] ^ exp_q[i]) & msk_q[i]) != 17'd0) begin
                bad++; $display("FAIL illegal cyc=%0d got=%h want=%h mask=%h", i, obs_q[i], exp_q[i], msk_q[i]);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        build(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3);
        drive(4);
        mem_ready = 1'b0;
        #1 total++;
        if (mem_write !== 1'b1) begin
            bad++; $display("FAIL midwr_pre mem_write got=%b want=1", mem_write);
        end
        #1 reset = 1'b0;
        #1 total++;
        if ({pc_write, mem_write, ir_write, reg_write, adr_src, alu_src_b, result_src} !== 9'b0000_0_10_10) begin
            bad++; $display("FAIL midwr_rst got=%b want=000001010", {pc_write, mem_write, ir_write, reg_write, adr_src, alu_src_b, result_src});
        end
        @(negedge clk);
        #1 total++;
        if ({mem_write, adr_src, alu_src_b} !== 4'b0_0_10) begin
            bad++; $display("FAIL midwr_hold got=%b want=0010", {mem_write, adr_src, alu_src_b});
        end
        @(negedge clk);
        reset = 1'b1;
        build(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);
        drive(exp_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            total++;
            if (((obs_q[i] ^ exp_q[i]) & msk_q[i]) != 17'd0) begin
                bad++; $display("FAIL midwr_resume cyc=%0d got=%h want=%h mask=%h", i, obs_q[i], exp_q[i], msk_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [7];
        logic [6:0] o;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0;
        for (int n = 0; n < 60; n++) begin
            o = ops[$urandom_range(6)];
            if (o == 7'b0) begin
                o = 7'($urandom);
                if (legal(o)) o = 7'b0001111;
            end
            build(o, 3'($urandom), rb(), rb(), $urandom_range(2), $urandom_range(2));
            drive(exp_q.size());
            for (int i = 0; i < obs_q.size(); i++) begin
                total++;
                if (((obs_q[i] ^ exp_q[i]) & msk_q[i]) != 17'd0) begin
                    bad++; $display("FAIL rand%0d op=%b cyc=%0d got=%h want=%h mask=%h", n, o, i, obs_q[i], exp_q[i], msk_q[i]);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_alu_decode();
        test_illegal();
        test_reset_midwrite();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
